// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Result is computed at capture and released to HI/LO after a fixed busy delay.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic               is_mul, is_div, sgn_div, a_neg, b_neg;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_wr;
    logic [CNT_W-1:0]   cnt;
    always_comb begin
        is_mul  = md_op == 3'd1 || md_op == 3'd2;
        is_div  = md_op == 3'd3 || md_op == 3'd4;
        sgn_div = md_op == 3'd3;
        a_neg   = rs_data[WIDTH-1];
        b_neg   = rt_data[WIDTH-1];
        mul_a   = {{WIDTH{md_op == 3'd1 && a_neg}}, rs_data};
        mul_b   = {{WIDTH{md_op == 3'd1 && b_neg}}, rt_data};
        prod    = mul_a * mul_b;
        // Signed divide runs on magnitudes; -2^(W-1) magnitude fits unsigned, so overflow wraps correctly.
        mag_a   = (sgn_div && a_neg) ? -rs_data : rs_data;
        mag_b   = (sgn_div && b_neg) ? -rt_data : rt_data;
        div_b   = (rt_data == '0) ? WIDTH'(1) : mag_b;
        q_mag   = mag_a / div_b;
        r_mag   = mag_a % div_b;
        quo     = (sgn_div && (a_neg ^ b_neg)) ? -q_mag : q_mag;
        rem     = (sgn_div && a_neg) ? -r_mag : r_mag;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (res_wr) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            end else if (start) begin
                if (md_op == 3'd5) hi <= rs_data;
                if (md_op == 3'd6) lo <= rs_data;
                if (is_mul || is_div) begin
                    busy   <= 1'b1;
                    cnt    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    res_hi <= is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
                    res_lo <= is_mul ? prod[WIDTH-1:0] : quo;
                    res_wr <= is_mul || rt_data != '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus random checks of md_unit against an arithmetic reference model.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sa, sb, q, r;
        logic [63:0] up;
        case (op)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'd2: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd3: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; drives the op, follows busy, checks timing and result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] ph, pl;
        int n, k;
        ph = m_hi; pl = m_lo;
        n = (op <= 3'd2) ? 5 : 10;
        model(op, a, b);
        start = 1'b1; md_op = op; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; md_op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
        if (op >= 3'd1 && op <= 3'd4) begin
            k = 0;
            while (busy === 1'b1 && k < 40) begin
                chk("hold_hi", hi, ph);
                chk("hold_lo", lo, pl);
                chk("done_early", done, 0);
                if (poke && k == 1) begin
                    start = 1'b1; md_op = 3'd6; rs_data = 32'hAAAA;
                end else begin
                    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
                end
                k++;
                @(negedge clk);
            end
            start = 1'b0;
            chk("busy_cycles", k, n);
            chk("done_pulse", done, 1);
        end else begin
            chk("busy_idle", busy, 0);
            chk("done_idle", done, 0);
        end
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    initial begin
        logic [31:0] b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_hi", hi, 0);
            chk("rst_lo", lo, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
        end
        run_op(3'd1, 32'hFFFFFFFE, 32'h3, 0);
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFFA);
        @(negedge clk);
        chk("done_once", done, 0);
        run_op(3'd2, 32'hFFFFFFFE, 32'h3, 0);
        chk("multu_hi_const", hi, 32'h2);
        run_op(3'd3, 32'hFFFFFFF9, 32'h2, 0);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);
        run_op(3'd4, 32'd7, 32'd2, 0);
        chk("divu_lo_const", lo, 32'd3);
        chk("divu_hi_const", hi, 32'd1);
        run_op(3'd5, 32'h1234, 32'h0, 0);
        run_op(3'd6, 32'h5678, 32'h0, 0);
        run_op(3'd3, 32'd99, 32'd0, 0);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);
        run_op(3'd4, 32'd5, 32'd0, 0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h0);
        run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 1);
        run_op(3'd7, 32'hDEAD, 32'hBEEF, 0);
        run_op(3'd0, 32'hDEAD, 32'hBEEF, 0);
        @(negedge clk);
        // Abort a mult in its third busy cycle.
        start = 1'b1; md_op = 3'd1; rs_data = 32'd1000; rt_data = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_done2", done, 0);
        run_op(3'd1, 32'd1000, 32'd1000, 0);
        chk("post_rst_lo", lo, 32'd1000000);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            run_op(3'($urandom_range(0, 7)), $urandom, b, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        chk("final_done", done, 0);
        chk("final_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo when E issues them.
- Raises busy for a configurable number of cycles.
- Exposes HI/LO for mfhi/mflo. The D-stage hazard logic stalls on start|busy.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  op valid this cycle (E stage holds md instruction).
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- rs_data  input  WIDTH  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  input  WIDTH  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight; HI/LO not yet valid.
- done  output  1  one-cycle pulse: HI/LO updated at this edge.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, counter=0, internal result regs=0. Reset mid-operation aborts the op; HI/LO stay 0.
- Accept condition: start=1 and busy=0 and md_op in 1..6. start while busy=1 is ignored; the CU guarantees it never happens, and the bench checks the ignore.
- mthi/mtlo (ops 5, 6): hi (resp. lo) <= rs_data at the accepting edge. busy stays 0. done stays 0.
- Mult/div (ops 1..4), at the accepting edge:
  - Operands are captured, so later rs/rt changes have no effect.
  - counter <= N, where N = MULT_CYCLES or DIV_CYCLES.
  - busy <= 1.
- Each busy cycle: counter decrements. On the edge where counter goes 1->0, the result is written to hi/lo, busy <= 0 and done <= 1 for one cycle.
- Latency: start at edge t gives busy high for cycles t+1..t+N. New hi/lo are visible from cycle t+N+1.
- hi/lo hold their old values throughout busy.
- mult: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits. multu: same, unsigned.
- div: lo = quotient, truncated toward zero; hi = remainder, same sign as dividend.
  - Overflow case: dividend = -2^(WIDTH-1) and divisor = -1 gives lo = -2^(WIDTH-1), hi = 0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu): timing is identical (busy N cycles, done pulses), but hi/lo are left unchanged.
- Reserved op 7, or md_op=0 with start: no state change.
- Implementation of the arithmetic is free: combinational at capture plus a delay counter, or an iterative shift-subtract/shift-add engine. Only the cycle-level contract and results above are binding.
- Simultaneous events: reset dominates start. An accept cannot coincide with the final busy edge, because busy=1 blocks it.
- Back-to-back: a new op is accepted in the cycle done=1 (busy already 0).

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0, done=0 for 3 cycles.
- mult, rs=0xFFFFFFFE (-2), rt=0x00000003, default params -> busy high exactly 5 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, rs=7, rt=2 -> lo=3, hi=1.
- Preload via mthi 0x1234, mtlo 0x5678 (each takes effect next cycle, busy stays 0). Then div rt=0 -> busy 10 cycles, done pulses, hi=0x1234, lo=0x5678 unchanged. div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mult issued, then start+mtlo with rs=0xAAAA during busy, plus operand changes mid-op -> mtlo ignored, result matches the captured operands.
- Reset asserted at busy cycle 3 of a mult -> next cycle busy=0, hi=lo=0, no done pulse. A new mult accepted immediately after reset completes normally.
